// File: rtl/seq_sweep_arb_pkg.sv
// seq_pkg: shared state type, default step width and pointer width helper for the sweep arbiter
package seq_pkg;
    localparam int STEP_W_DEF = 3;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/seq_sweep_arb_if.sv
// seq_sweep_arb_if: request/grant and step bus between channel control and the shared sequencer
interface seq_sweep_arb_if #(parameter int NREQ = 4, parameter int STEP_W = 3);
    logic [NREQ-1:0]        req;
    logic [NREQ*STEP_W-1:0] len;
    logic                   abort;
    logic [NREQ-1:0]        gnt;
    logic [STEP_W-1:0]      step;
    logic                   step_vld;
    logic                   last;
    logic [NREQ-1:0]        done;
    logic                   busy;
    modport master (output req, len, abort, input gnt, step, step_vld, last, done, busy);
    modport slave (input req, len, abort, output gnt, step, step_vld, last, done, busy);
endinterface

// File: rtl/seq_sweep_arb_rr_pick.sv
// seq_rr_pick: combinational round-robin picker, first set request at or after ptr wins
module seq_rr_pick import seq_pkg::*; #(
    parameter int NREQ = 4,
    parameter int PW = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   win_idx
);
    logic [PW-1:0] c;
    // walk from farthest to nearest so the candidate closest to ptr is written last
    always_comb begin
        win = '0;
        win_idx = '0;
        c = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            c = PW'((int'(ptr) + k) % NREQ);
            if (req[c]) begin
                win = '0;
                win[c] = 1'b1;
                win_idx = c;
            end
        end
    end
endmodule

// File: rtl/seq_sweep_arb.sv
// seq_sweep_arb: round-robin owner of a shared step sequencer, sweeps 0..len and pulses done
module seq_sweep_arb import seq_pkg::*; #(
    parameter int NREQ = 4,
    parameter int STEP_W = STEP_W_DEF
) (
    input logic          clk,
    input logic          rst_n,
    seq_sweep_arb_if.slave bus
);
    localparam int PW = ptr_w(NREQ);
    state_t state, state_n;
    logic [PW-1:0] ptr, ptr_n, owner, owner_n, win_idx, nxt_ptr;
    logic [NREQ-1:0] win, gnt_n, done_n;
    logic [STEP_W-1:0] len_q, len_n, step_n, win_len, step_inc;
    logic vld_n, last_n;
    seq_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (.req(bus.req), .ptr(ptr), .win(win), .win_idx(win_idx));
    assign win_len = bus.len[int'(win_idx) * STEP_W +: STEP_W];
    assign nxt_ptr = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
    assign step_inc = bus.step + 1'b1;
    assign bus.busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            owner <= '0;
            len_q <= '0;
            bus.gnt <= '0;
            bus.step <= '0;
            bus.step_vld <= 1'b0;
            bus.last <= 1'b0;
            bus.done <= '0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            owner <= owner_n;
            len_q <= len_n;
            bus.gnt <= gnt_n;
            bus.step <= step_n;
            bus.step_vld <= vld_n;
            bus.last <= last_n;
            bus.done <= done_n;
        end
    end
    // abort and withdraw outrank both the last-step exit and the normal advance
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        owner_n = owner;
        len_n = len_q;
        gnt_n = '0;
        step_n = bus.step;
        vld_n = 1'b0;
        last_n = 1'b0;
        done_n = '0;
        case (state)
            IDLE: if (|bus.req && !bus.abort) begin
                state_n = RUN;
                owner_n = win_idx;
                len_n = win_len;
                gnt_n = win;
                step_n = '0;
                vld_n = 1'b1;
                last_n = win_len == '0;
            end
            RUN: if (bus.abort || !bus.req[owner]) begin
                state_n = IDLE;
                ptr_n = nxt_ptr;
                step_n = '0;
            end else if (bus.last) begin
                state_n = DONE;
                ptr_n = nxt_ptr;
                done_n = bus.gnt;
            end else begin
                gnt_n = bus.gnt;
                vld_n = 1'b1;
                step_n = step_inc;
                last_n = step_inc == len_q;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_seq_sweep_arb.sv
// tb_seq_sweep_arb: directed test plan plus randomized traffic checked against a behavioural model
module tb_seq_sweep_arb;
    localparam int NREQ = 4;
    localparam int SW = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;
    seq_sweep_arb_if #(.NREQ(NREQ), .STEP_W(SW)) bus ();
    seq_sweep_arb #(.NREQ(NREQ), .STEP_W(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    // ph: 0 idle, 1 sweeping, 2 done pulse; st/ln/ow/pt: step, latched len, owner, rr pointer
    typedef struct {int ph; int st; int ln; int ow; int pt;} mdl_t;
    mdl_t m;

    function automatic mdl_t nxt(mdl_t c, logic [NREQ-1:0] rq, logic [NREQ*SW-1:0] ln, logic ab);
        mdl_t r = c;
        bit f = 1'b0;
        int w;
        if (c.ph == 0) begin
            if (rq != 0 && !ab) begin
                for (int k = 0; k < NREQ; k++) begin
                    w = (c.pt + k) % NREQ;
                    if (!f && ((rq >> w) & 1) != 0) begin
                        f = 1'b1;
                        r.ow = w;
                    end
                end
                r.ln = int'((ln >> (SW * r.ow)) & 7);
                r.st = 0;
                r.ph = 1;
            end
        end else if (c.ph == 1) begin
            if (ab || ((rq >> c.ow) & 1) == 0) begin
                r.ph = 0;
                r.st = 0;
                r.pt = (c.ow + 1) % NREQ;
            end else if (c.st == c.ln) begin
                r.ph = 2;
                r.pt = (c.ow + 1) % NREQ;
            end else r.st = c.st + 1;
        end else r.ph = 0;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m <= '{default: 0};
        else m <= nxt(m, bus.req, bus.len, bus.abort);

    task automatic chk(input string nm, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, want, $time);
        end
    endtask

    always @(negedge clk) if (cmp_on) begin
        chk("m_gnt", int'(bus.gnt), m.ph == 1 ? (1 << m.ow) : 0);
        chk("m_step", int'(bus.step), m.st);
        chk("m_vld", int'(bus.step_vld), int'(m.ph == 1));
        chk("m_last", int'(bus.last), int'(m.ph == 1 && m.st == m.ln));
        chk("m_done", int'(bus.done), m.ph == 2 ? (1 << m.ow) : 0);
        chk("m_busy", int'(bus.busy), int'(m.ph != 0));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = '0;
        bus.len = '0;
        bus.abort = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_gnt"}, int'(bus.gnt), 0);
        chk({nm, "_step"}, int'(bus.step), 0);
        chk({nm, "_vld"}, int'(bus.step_vld), 0);
        chk({nm, "_last"}, int'(bus.last), 0);
        chk({nm, "_done"}, int'(bus.done), 0);
        chk({nm, "_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        int gq[$];
        int gc[$];
        int rr_exp[5] = '{0, 1, 2, 3, 0};
        int n;
        logic [NREQ-1:0] pg;
        bus.req = '0;
        bus.len = '0;
        bus.abort = 1'b0;
        cmp_on = 1'b1;
        do_reset();
        chk_zero("reset");

        bus.req = 4'b0001;
        bus.len = 12'd7;
        tick();
        chk("single_gnt", int'(bus.gnt), 1);
        for (int k = 0; k < 8; k++) begin
            chk("single_step", int'(bus.step), k);
            chk("single_last", int'(bus.last), int'(k == 7));
            tick();
        end
        chk("single_done", int'(bus.done), 1);
        chk("single_done_vld", int'(bus.step_vld), 0);
        chk("single_done_busy", int'(bus.busy), 1);
        bus.req = '0;
        tick();
        chk("single_idle_busy", int'(bus.busy), 0);
        chk("single_idle_done", int'(bus.done), 0);

        do_reset();
        bus.req = 4'b1111;
        bus.len = 12'h249;
        pg = '0;
        for (int c = 0; c < 40 && gq.size() < 5; c++) begin
            tick();
            if (bus.gnt != 0 && pg == 0)
                for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) begin
                    gq.push_back(i);
                    gc.push_back(c);
                end
            pg = bus.gnt;
        end
        chk("rr_count", gq.size(), 5);
        for (int i = 0; i < gq.size(); i++) chk("rr_order", gq[i], rr_exp[i]);
        if (gc.size() > 1) chk("rr_spacing", gc[1] - gc[0], 4);
        bus.req = '0;
        repeat (3) tick();

        do_reset();
        bus.req = 4'b0100;
        tick();
        chk("len0_gnt", int'(bus.gnt), 4);
        chk("len0_step", int'(bus.step), 0);
        chk("len0_last", int'(bus.last), 1);
        chk("len0_vld", int'(bus.step_vld), 1);
        tick();
        chk("len0_done", int'(bus.done), 4);
        chk("len0_vld_off", int'(bus.step_vld), 0);
        bus.req = '0;
        tick();

        do_reset();
        bus.req = 4'b0010;
        bus.len = 12'd7 << 3;
        tick();
        chk("abort_gnt", int'(bus.gnt), 2);
        repeat (3) tick();
        chk("abort_at_step", int'(bus.step), 3);
        bus.abort = 1'b1;
        tick();
        chk_zero("abort");
        bus.abort = 1'b0;
        bus.req = 4'b0011;
        tick();
        chk("abort_next_gnt", int'(bus.gnt), 1);
        bus.req = '0;
        repeat (2) tick();

        do_reset();
        bus.req = 4'b1000;
        bus.len = 12'd7 << 9;
        repeat (3) tick();
        chk("wd_step", int'(bus.step), 2);
        bus.req = '0;
        bus.len = 12'd2 << 9;
        tick();
        chk_zero("withdraw");
        tick();
        chk("wd_no_done", int'(bus.done), 0);

        do_reset();
        bus.req = 4'b1000;
        bus.len = 12'd5 << 9;
        tick();
        bus.len = 12'd1 << 9;
        n = 0;
        for (int c = 0; c < 20 && bus.step_vld; c++) begin
            if (bus.last) chk("latch_last_step", int'(bus.step), 5);
            n++;
            tick();
        end
        chk("latch_vld_cycles", n, 6);
        chk("latch_done", int'(bus.done), 8);
        bus.req = '0;
        tick();

        do_reset();
        bus.req = 4'b0001;
        bus.len = 12'd7;
        repeat (2) tick();
        chk("arst_pre_busy", int'(bus.busy), 1);
        #1 rst_n = 1'b0;
        #1 chk_zero("arst");
        bus.req = '0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        bus.req = 4'b0010;
        tick();
        chk("arst_regrant", int'(bus.gnt), 2);
        bus.req = '0;
        repeat (2) tick();

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req = NREQ'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) bus.len = 12'($urandom);
            bus.abort = $urandom_range(0, 24) == 0;
            tick();
        end
        bus.req = '0;
        bus.abort = 1'b0;
        repeat (3) tick();
        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_sweep_arb.md
Name: seq_sweep_arb

Overview:
Shares one 3-bit step sequencer (s0..s7 phase counter) among NREQ requesters. The block arbitrates round-robin and grants the sequencer to one owner. It then sweeps the step index from 0 up to the owner's programmed last step and pulses done to that owner. It sits between the per-channel control logic and the phase-driven datapath and owns all sequencing of the step counter.

Parameters:
NREQ, 4, number of requesters (2..8)
STEP_W, 3, step index width; sweep length is at most 2**STEP_W steps

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req  in  NREQ  per-requester sweep request, level, held until done or withdrawn
len  in  NREQ*STEP_W  per-requester last step index, slice i = len[i*STEP_W +: STEP_W]
abort  in  1  global sweep abort, synchronous
gnt  out  NREQ  one-hot grant, high for the owner's whole sweep
step  out  STEP_W  current step index driven to the datapath
step_vld  out  1  step is valid this cycle
last  out  1  step equals latched last index
done  out  NREQ  one-cycle completion pulse to the owner
busy  out  1  state is not IDLE

Behaviour:
- Clock and reset: clk, rising edge; rst_n asynchronous, active-low.
- Reset values: state IDLE; gnt, step, step_vld, last, done and busy all 0; rr pointer ptr = 0; latched length = 0.
- Reset mid-sweep: all outputs clear immediately. No done pulse is produced.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - If req is nonzero, pick the first set bit searching ptr, ptr+1, ... wrapping modulo NREQ.
  - At the next edge: gnt = onehot(winner), latch len slice of the winner, step = 0, step_vld = 1, busy = 1, go to RUN.
  - Latency: req high in cycle t gives gnt and step 0 in cycle t+1.
  - If abort is high in IDLE, no grant is issued that cycle.
- RUN:
  - Each edge, step increments by 1 while step is not equal to the latched length.
  - last = 1 in the cycle where step equals the latched length.
  - At the edge after last: go to DONE, step_vld = 0, gnt = 0, done[owner] = 1.
  - Sweep occupies exactly len+1 cycles of step_vld. len = 0 gives a single step 0. len = 7 gives a full 0..7 sweep with no wrap.
- DONE:
  - Lasts one cycle: done pulse high, busy = 1, step held at its final value.
  - ptr updates to owner+1 mod NREQ.
  - Next edge goes to IDLE with done = 0.
  - Minimum spacing between grants is 2 idle cycles after the last step.
- Withdraw or abort: if abort = 1, or req[owner] = 0 while in RUN:
  - At the next edge go to IDLE.
  - gnt, step_vld and last go to 0; step goes to 0.
  - No done pulse. ptr still advances to owner+1.
  - abort has priority over normal step advance and over last.
- Changes to len during RUN are ignored; only the value latched at grant is used.
- Non-owner req changes during RUN have no effect until IDLE.
- Invariants:
  - gnt is at most one-hot.
  - done is at most one-hot, and only for the previous owner.
  - step_vld = 1 implies gnt is nonzero.
  - step never exceeds the latched length.

Decomposition:
- Shared package seq_pkg: state enum {IDLE, RUN, DONE}, STEP_W default, width helper for the ptr (clog2 NREQ).
- One sub-module, seq_rr_pick: purely combinational round-robin priority picker.
  - Inputs: req, ptr.
  - Outputs: one-hot winner and its index.
- Top module: FSM, step counter, length latch, ptr register.

Test Plan:
- Single requester: req = 0001, len0 = 7. Required: gnt = 0001 from cycle t+1; step 0..7 over 8 cycles; last only at step 7; done = 0001 one cycle later; busy drops the cycle after that.
- Round-robin: req = 1111 held, all len = 1. Required: grants in order 0,1,2,3,0. Each grant gives steps 0,1, then a done pulse to that owner, then an IDLE gap before the next grant.
- Length extremes: len2 = 0 with only req[2] set. Required: one step_vld cycle with step = 0 and last = 1, then done = 0100.
- Abort mid-sweep: owner 1, len = 7, abort pulsed at step 3. Required: next cycle gnt = 0, step_vld = 0, step = 0, no done pulse, ptr = 2. With req = 0011 held, the next grant goes to 0.
- Withdraw plus len change: owner 3 drops req at step 2 and len3 changes mid-sweep. Required: the sweep ends without done. In a separate run, a len change during RUN does not alter the latched last index.
- Async reset: assert rst_n low mid-RUN, between clock edges. Required: all outputs 0 immediately. After release, req = 0010 is granted with ptr starting at 0, so requester 1 wins.
